pipe_stage_buf: RTL

Parametrised pipeline-stage register for the five-stage core. It is the generalised successor of the fixed ID/EX latch: an arbitrary-width payload, a valid/ready handshake instead of the global stall vector, and a 2-entry skid buffer so the ready path is fully registered. It also supports flush (branch/jump kill) and guarantees NOP bubbles. One instance sits between each pair of stages (IF/ID, ID/EX, EX/MEM, MEM/WB).

---
 rtl/pipe_stage_buf.sv | 137 +++++++++++++
 1 files changed

// File: rtl/pipe_stage_buf.sv
// Pipeline-stage register with valid/ready handshake, optional 2-entry skid buffer and flush.
// Optional performance counters (bubble/backpressure) are built when PIPE_STAGE_PERF_EN is defined.
module pipe_stage_buf #(
    parameter int unsigned       DATA_W  = 128,
    parameter logic [DATA_W-1:0] NOP_VAL = {DATA_W{1'b0}},
    parameter bit                SKID    = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
`ifdef PIPE_STAGE_PERF_EN
    ,
    output logic [31:0]       bubble_cnt,
    output logic [31:0]       backpressure_cnt
`endif
);

    // Encoding doubles as the occupancy count.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t            state_r, state_s;
    logic [DATA_W-1:0] main_r, main_s;
    logic [DATA_W-1:0] skid_r, skid_s;
    logic              in_ready_r, in_ready_s;
    logic              accept_s, emit_s;

    assign out_valid = (state_r != ST_EMPTY);
    assign out_data  = main_r;
    assign occupancy = state_r;
    // Without the skid entry the ready path must look through to downstream.
    assign in_ready  = SKID ? in_ready_r : (!out_valid || out_ready);
    assign accept_s  = in_valid && in_ready;
    assign emit_s    = out_valid && out_ready;

    // Next-state and next-payload selection.
    always_comb begin
        state_s = state_r;
        main_s  = main_r;
        skid_s  = skid_r;
        if (flush) begin
            state_s = ST_EMPTY;
            main_s  = NOP_VAL;
            skid_s  = NOP_VAL;
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    if (accept_s) begin
                        state_s = ST_ONE;
                        main_s  = in_data;
                    end else begin
                        state_s = ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    if (accept_s && emit_s) begin
                        main_s = in_data;
                    end else if (accept_s) begin
                        if (SKID) begin
                            state_s = ST_FULL;
                            skid_s  = in_data;
                        end else begin
                            main_s = in_data;
                        end
                    end else if (emit_s) begin
                        state_s = ST_EMPTY;
                        main_s  = NOP_VAL;
                    end else begin
                        state_s = ST_ONE;
                    end
                end
                ST_FULL: begin
                    if (emit_s) begin
                        state_s = ST_ONE;
                        main_s  = skid_r;
                        skid_s  = NOP_VAL;
                    end else begin
                        state_s = ST_FULL;
                    end
                end
                default: begin
                    state_s = ST_EMPTY;
                    main_s  = NOP_VAL;
                    skid_s  = NOP_VAL;
                end
            endcase
        end
        in_ready_s = (state_s != ST_FULL);
    end

    // State, payload and registered-ready update.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_EMPTY;
            main_r     <= NOP_VAL;
            skid_r     <= NOP_VAL;
            in_ready_r <= 1'b1;
        end else begin
            state_r    <= state_s;
            main_r     <= main_s;
            skid_r     <= skid_s;
            in_ready_r <= in_ready_s;
        end
    end

`ifdef PIPE_STAGE_PERF_EN
    // Stall statistics; deliberately survive flush and wrap naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            bubble_cnt       <= 32'd0;
            backpressure_cnt <= 32'd0;
        end else begin
            if (out_ready && !out_valid) begin
                bubble_cnt <= bubble_cnt + 32'd1;
            end else begin
                bubble_cnt <= bubble_cnt;
            end
            if (out_valid && !out_ready) begin
                backpressure_cnt <= backpressure_cnt + 32'd1;
            end else begin
                backpressure_cnt <= backpressure_cnt;
            end
        end
    end
`endif

endmodule
